sram_wr_fifo: RTL

- Downstream stage of the PXA-to-BRAM SRAM bus bridge.
- Captures each single-cycle write strobe (`we`, `addr`, `data`) that the bridge issues toward block RAM. Queues each as a command in a small FIFO.
- Presents queued commands to FPGA-side consumers (motor/PWM/servo register blocks) over a valid/ready handshake, so processor writes are never lost while a consumer is busy.
- Single clock domain, same clock as the bridge's write-side logic.

---
 rtl/sram_bus_pkg.sv | 18 +
 rtl/sram_wr_fifo_mem.sv | 27 ++
 rtl/sram_wr_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM bus bridge: bus widths, write-command payload
// and the FIFO pointer width helper.
package sram_bus_pkg;

  localparam int unsigned SRAM_AW = 10;
  localparam int unsigned SRAM_DW = 16;

  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] data;
  } sram_wr_cmd_t;

  // Pointer/level width: one extra bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/sram_wr_fifo_mem.sv
// Simple dual-port storage for the write FIFO: one synchronous write port and
// one asynchronous read port, suitable for distributed RAM.
module sram_wr_fifo_mem #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned W     = 26
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata_c
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/sram_wr_fifo.sv
// Write-command FIFO behind the SRAM bus bridge: captures write strobes and
// hands them to consumers over valid/ready. Optional address window: SRAM_WR_FIFO_FILTER_EN.
module sram_wr_fifo
  import sram_bus_pkg::*;
#(
  parameter int unsigned    AW         = SRAM_AW,
  parameter int unsigned    DW         = SRAM_DW,
  parameter int unsigned    DEPTH_LOG2 = 4,
  parameter logic [AW-1:0]  WIN_BASE   = AW'(10'h000),
  parameter logic [AW-1:0]  WIN_LAST   = AW'(10'h3FF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [AW-1:0]       out_addr,
  output logic [DW-1:0]       out_data,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                overflow,
  input  logic                clr_ovf
);

  localparam int unsigned    PW      = ptr_width(DEPTH_LOG2);
  localparam int unsigned    CMD_W   = $bits(sram_wr_cmd_t);
  localparam logic [PW-1:0]  DEPTH_L = PW'(1 << DEPTH_LOG2);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] level_after_pop;
  logic [PW-1:0] level_next;
  logic          in_win;
  logic          pop;
  logic          push;
  logic          drop;
  logic [CMD_W-1:0] rd_raw;
  sram_wr_cmd_t  wr_cmd;
  sram_wr_cmd_t  rd_cmd;
  sram_wr_cmd_t  head;

`ifdef SRAM_WR_FIFO_FILTER_EN
  assign in_win = (wr_addr >= WIN_BASE) && (wr_addr <= WIN_LAST);
`else
  logic unused_win;
  assign unused_win = ^{WIN_BASE, WIN_LAST};
  assign in_win     = 1'b1;
`endif

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop             = out_valid & out_ready;
  assign push            = wr_we & in_win & (~full | pop);
  assign drop            = wr_we & in_win & full & ~pop;
  assign rd_ptr_next     = rd_ptr + PW'(pop);
  assign level_after_pop = level - PW'(pop);
  assign level_next      = level_after_pop + PW'(push);

  assign wr_cmd = '{addr: SRAM_AW'(wr_addr), data: SRAM_DW'(wr_data)};
  assign rd_cmd = sram_wr_cmd_t'(rd_raw);

  // Next head: bypass the incoming write when nothing else remains queued.
  always_comb begin
    head = rd_cmd;
    if (level_after_pop == '0) begin
      head = wr_cmd;
    end
  end

  sram_wr_fifo_mem #(
    .IDX_W (DEPTH_LOG2),
    .W     (CMD_W)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .waddr   (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata   (wr_cmd),
    .raddr   (rd_ptr_next[DEPTH_LOG2-1:0]),
    .rdata_c (rd_raw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(push);
      rd_ptr    <= rd_ptr_next;
      level     <= level_next;
      full      <= (level_next == DEPTH_L);
      out_valid <= (level_next != '0);
      // Output register only moves when the head is consumed or was empty.
      if ((pop || !out_valid) && (level_next != '0)) begin
        out_addr <= AW'(head.addr);
        out_data <= DW'(head.data);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
